// File: rtl/mem_loader_pkg.sv
// Shared types and field widths for the byte-stream data memory loader.
// Optional build macro: LOADER_CHECKSUM_EN adds the trailing checksum state.
package mem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE
`ifdef LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    // Big-endian assembly: earlier bytes end up in the high bits.
    function automatic logic [WORD_W-1:0] shift_byte(input logic [WORD_W-1:0] word,
                                                     input logic [7:0] b);
        return {word[WORD_W-9:0], b};
    endfunction

endpackage

// File: rtl/mem_loader_timeout.sv
// Reloadable inter-byte watchdog. Reloads on 'load', counts down while
// 'enable' is high, and flags 'expired' once the count has run out.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Down-counter: reload wins, otherwise decrement and saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= RELOAD;
        else if (load)
            cnt <= RELOAD;
        else if (enable && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    // Only meaningful while the owner is waiting on a byte.
    always_comb begin
        expired = enable && (cnt == '0);
    end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream loader: parses SYNC/LEN_HI/LEN_LO/payload frames from the UART
// and writes big-endian words into word-indexed data memory, holding the CPU
// off while a frame is in flight.
// Optional build macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                MAX_WORDS      = 256,
    parameter logic [7:0]        SYNC_BYTE      = SYNC_DEFAULT,
    parameter int                TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [WORD_W-1:0]  word_q;
    logic [1:0]         byte_idx_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   words_q;
    logic               error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    logic               accept;
    logic               sync_seen;
    logic [LEN_W-1:0]   len_full;
    logic               len_bad;
    logic [LEN_W-1:0]   words_inc;
    logic               last_word;
    logic               in_frame;
    logic               tmo_expired;
    logic               timeout_hit;

    // Shared decode used by both the FSM and the datapath.
    always_comb begin
        accept      = in_valid && in_ready;
        sync_seen   = accept && (in_data == SYNC_BYTE);
        len_full    = {len_q[LEN_W-1:8], in_data};
        len_bad     = len_full > MAX_LEN;
        words_inc   = words_q + LEN_W'(1);
        last_word   = words_inc == len_q;
        in_frame    = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state_q == CHECK)
`endif
                      ;
        // A byte landing on the expiry cycle still counts as on time.
        timeout_hit = tmo_expired && !accept;
    end

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .enable  (in_frame),
        .expired (tmo_expired)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (sync_seen) state_d = LEN_HI;
            LEN_HI: begin
                if (timeout_hit)  state_d = IDLE;
                else if (accept)  state_d = LEN_LO;
            end
            LEN_LO: begin
                if (timeout_hit) state_d = IDLE;
                else if (accept) begin
                    if (len_full == '0) state_d = DONE;
                    else if (len_bad)   state_d = IDLE;
                    else                state_d = DATA;
                end
            end
            DATA: begin
                if (timeout_hit)                        state_d = IDLE;
                else if (accept && byte_idx_q == 2'd3)  state_d = WRITE;
            end
            WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_d = last_word ? CHECK : DATA;
`else
                state_d = last_word ? DONE : DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (timeout_hit)  state_d = IDLE;
                else if (accept)  state_d = (in_data == csum_q) ? DONE : IDLE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, all decoded from the current state.
    always_comb begin
        in_ready  = 1'b1;
        mem_write = 1'b0;
        cpu_hold  = 1'b0;
        done      = 1'b0;
        case (state_q)
            LEN_HI, LEN_LO, DATA: cpu_hold = 1'b1;
            WRITE: begin
                in_ready  = 1'b0;
                mem_write = 1'b1;
                cpu_hold  = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: cpu_hold = 1'b1;
`endif
            DONE: begin
                in_ready = 1'b0;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame datapath: length capture, word assembly, address/count, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            addr_q     <= BASE_ADDR;
            words_q    <= '0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (sync_seen) begin
                        error_q <= 1'b0;
                        words_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (timeout_hit) error_q <= 1'b1;
                    else if (accept) begin
                        len_q[LEN_W-1:8] <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                    end
                end
                LEN_LO: begin
                    if (timeout_hit) error_q <= 1'b1;
                    else if (accept) begin
                        len_q[7:0] <= in_data;
                        byte_idx_q <= '0;
                        addr_q     <= BASE_ADDR;
                        if (len_bad) error_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                    end
                end
                DATA: begin
                    if (timeout_hit) error_q <= 1'b1;
                    else if (accept) begin
                        word_q     <= shift_byte(word_q, in_data);
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                    end
                end
                WRITE: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    words_q <= words_inc;
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (timeout_hit)                     error_q <= 1'b1;
                    else if (accept && in_data != csum_q) error_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign mem_address    = addr_q;
    assign mem_write_data = word_q;
    assign error          = error_q;
    assign words_loaded   = words_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader (inter-byte timeout shortened to 16).
module tb_mem_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cnt = 0;

    mem_loader #(
        .BASE_ADDR      (32'd0),
        .MAX_WORDS      (256),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .cpu_hold       (cpu_hold),
        .done           (done),
        .error          (error),
        .words_loaded   (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor, sampled away from the rising edge.
    always @(negedge clk) begin
        if (mem_write) begin
            wr_addr.push_back(mem_address);
            wr_data.push_back(mem_write_data);
        end
        if (done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_byte_ready got=in_ready low for %0d cycles want=ready", waited);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        total++; if (in_ready !== 1'b1)        begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (mem_write !== 1'b0)       begin bad++; $display("FAIL reset_mem_write got=%b want=0", mem_write); end
        total++; if (mem_address !== 32'd0)   begin bad++; $display("FAIL reset_addr got=%h want=0", mem_address); end
        total++; if (mem_write_data !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_write_data); end
        total++; if (cpu_hold !== 1'b0)        begin bad++; $display("FAIL reset_cpu_hold got=%b want=0", cpu_hold); end
        total++; if (done !== 1'b0)            begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (error !== 1'b0)           begin bad++; $display("FAIL reset_error got=%b want=0", error); end
        total++; if (words_loaded !== 16'd0)   begin bad++; $display("FAIL reset_words got=%0d want=0", words_loaded); end
    endtask

    task automatic test_two_words();
        int w0, d0;
        w0 = wr_addr.size(); d0 = done_cnt;
        send_byte(8'hA5);
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL two_hold_after_sync got=%b want=1", cpu_hold); end
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        total++; if (mem_write !== 1'b1 || mem_write_data !== 32'h11223344)
            begin bad++; $display("FAIL two_write_latency got=%b/%h want=1/11223344", mem_write, mem_write_data); end
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h8A);
`endif
        idle(4);
        total++; if (wr_addr.size() - w0 !== 2) begin bad++; $display("FAIL two_write_count got=%0d want=2", wr_addr.size() - w0); end
        if (wr_addr.size() - w0 == 2) begin
            total++; if (wr_addr[w0] !== 32'd0 || wr_data[w0] !== 32'h11223344)
                begin bad++; $display("FAIL two_word0 got=%h:%h want=0:11223344", wr_addr[w0], wr_data[w0]); end
            total++; if (wr_addr[w0+1] !== 32'd1 || wr_data[w0+1] !== 32'h55667788)
                begin bad++; $display("FAIL two_word1 got=%h:%h want=1:55667788", wr_addr[w0+1], wr_data[w0+1]); end
        end
        total++; if (done_cnt - d0 !== 1)      begin bad++; $display("FAIL two_done got=%0d want=1", done_cnt - d0); end
        total++; if (words_loaded !== 16'd2)   begin bad++; $display("FAIL two_words got=%0d want=2", words_loaded); end
        total++; if (cpu_hold !== 1'b0)        begin bad++; $display("FAIL two_hold_end got=%b want=0", cpu_hold); end
        total++; if (error !== 1'b0)           begin bad++; $display("FAIL two_error got=%b want=0", error); end
    endtask

    task automatic test_drop_and_empty();
        int w0, d0;
        w0 = wr_addr.size(); d0 = done_cnt;
        send_byte(8'h00); send_byte(8'hFF);
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL drop_hold got=%b want=0", cpu_hold); end
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        idle(3);
        total++; if (wr_addr.size() - w0 !== 0) begin bad++; $display("FAIL empty_writes got=%0d want=0", wr_addr.size() - w0); end
        total++; if (done_cnt - d0 !== 1)        begin bad++; $display("FAIL empty_done got=%0d want=1", done_cnt - d0); end
        total++; if (error !== 1'b0)             begin bad++; $display("FAIL empty_error got=%b want=0", error); end
        total++; if (words_loaded !== 16'd0)     begin bad++; $display("FAIL empty_words got=%0d want=0", words_loaded); end
    endtask

    task automatic test_len_error();
        int w0, d0;
        w0 = wr_addr.size(); d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        idle(2);
        total++; if (error !== 1'b1)             begin bad++; $display("FAIL len_error got=%b want=1", error); end
        total++; if (wr_addr.size() - w0 !== 0)  begin bad++; $display("FAIL len_writes got=%0d want=0", wr_addr.size() - w0); end
        total++; if (in_ready !== 1'b1)          begin bad++; $display("FAIL len_in_ready got=%b want=1", in_ready); end
        total++; if (cpu_hold !== 1'b0)          begin bad++; $display("FAIL len_hold got=%b want=0", cpu_hold); end
        total++; if (done_cnt - d0 !== 0)        begin bad++; $display("FAIL len_done got=%0d want=0", done_cnt - d0); end
    endtask

    task automatic test_timeout();
        int w0, d0;
        w0 = wr_addr.size(); d0 = done_cnt;
        send_byte(8'hA5);
        total++; if (error !== 1'b0) begin bad++; $display("FAIL tmo_sync_clears_error got=%b want=0", error); end
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
        idle(5);
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL tmo_hold_before got=%b want=1", cpu_hold); end
        idle(30);
        total++; if (error !== 1'b1)            begin bad++; $display("FAIL tmo_error got=%b want=1", error); end
        total++; if (wr_addr.size() - w0 !== 0) begin bad++; $display("FAIL tmo_writes got=%0d want=0", wr_addr.size() - w0); end
        total++; if (cpu_hold !== 1'b0)         begin bad++; $display("FAIL tmo_hold got=%b want=0", cpu_hold); end
        total++; if (done_cnt - d0 !== 0)       begin bad++; $display("FAIL tmo_done got=%0d want=0", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_frame();
        int w0, d0;
        w0 = wr_addr.size(); d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        @(negedge clk); rst_n = 1'b0;
        idle(2);
        total++; if (cpu_hold !== 1'b0 || mem_address !== 32'd0 || error !== 1'b0)
            begin bad++; $display("FAIL rst_mid_state got=hold%b addr%h err%b want=0/0/0", cpu_hold, mem_address, error); end
        rst_n = 1'b1;
        idle(1);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h31);
`endif
        idle(3);
        total++; if (wr_addr.size() - w0 !== 1) begin bad++; $display("FAIL rst_mid_count got=%0d want=1", wr_addr.size() - w0); end
        if (wr_addr.size() - w0 == 1) begin
            total++; if (wr_addr[w0] !== 32'd0 || wr_data[w0] !== 32'hCAFEBABE)
                begin bad++; $display("FAIL rst_mid_word got=%h:%h want=0:cafebabe", wr_addr[w0], wr_data[w0]); end
        end
        total++; if (done_cnt - d0 !== 1)    begin bad++; $display("FAIL rst_mid_done got=%0d want=1", done_cnt - d0); end
        total++; if (words_loaded !== 16'd1) begin bad++; $display("FAIL rst_mid_words got=%0d want=1", words_loaded); end
    endtask

    task automatic test_max_len();
        int w0, d0;
        w0 = wr_addr.size(); d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 1024; i++) send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h01);
`endif
        idle(3);
        total++; if (wr_addr.size() - w0 !== 256) begin bad++; $display("FAIL max_count got=%0d want=256", wr_addr.size() - w0); end
        if (wr_addr.size() - w0 == 256) begin
            total++; if (wr_addr[w0+255] !== 32'd255) begin bad++; $display("FAIL max_last_addr got=%h want=ff", wr_addr[w0+255]); end
        end
        total++; if (words_loaded !== 16'd256) begin bad++; $display("FAIL max_words got=%0d want=256", words_loaded); end
        total++; if (done_cnt - d0 !== 1 || error !== 1'b0)
            begin bad++; $display("FAIL max_done got=done%0d err%b want=1/0", done_cnt - d0, error); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int w0, d0;
        w0 = wr_addr.size(); d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05);
        idle(3);
        total++; if (done_cnt - d0 !== 1 || error !== 1'b0)
            begin bad++; $display("FAIL csum_good got=done%0d err%b want=1/0", done_cnt - d0, error); end
        w0 = wr_addr.size(); d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h06);
        idle(3);
        total++; if (error !== 1'b1)       begin bad++; $display("FAIL csum_bad_error got=%b want=1", error); end
        total++; if (done_cnt - d0 !== 0)  begin bad++; $display("FAIL csum_bad_done got=%0d want=0", done_cnt - d0); end
        total++; if (wr_addr.size() - w0 !== 1) begin bad++; $display("FAIL csum_bad_writes got=%0d want=1", wr_addr.size() - w0); end
        if (wr_addr.size() - w0 == 1) begin
            total++; if (wr_addr[w0] !== 32'd0 || wr_data[w0] !== 32'h01020304)
                begin bad++; $display("FAIL csum_bad_word got=%h:%h want=0:01020304", wr_addr[w0], wr_data[w0]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_drop_and_empty();
        test_len_error();
        test_timeout();
        test_reset_mid_frame();
        test_max_len();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
